// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Optional build macro: DIV_FLUSH_EN (adds a pipeline flush input to div_unit_seq).
package div_pkg;

  // Default operand/result width; the iteration count equals the width.
  localparam int DIV_WIDTH = 32;

  // Iteration counter width for the default operand width.
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  // Quotient reported when dividing by zero (all ones).
  localparam logic [DIV_WIDTH-1:0] DIV_DBZ_QUOT = '1;

  // Divider sequencing states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor magnitude, keep or restore.
module div_sub_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  // The shifted partial remainder keeps the old remainder MSB so that divisor
  // magnitudes at or above 2^(WIDTH-1) still divide correctly; because the
  // remainder is always below the divisor, the WIDTH+1-bit difference cannot
  // wrap and its top bit is a reliable borrow.
  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;

  assign partial  = {rem, dvd_bit};
  assign diff     = partial - {1'b0, dvs};
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];

endmodule

// File: rtl/div_unit_seq.sv
// Iterative restoring integer divider (DIV/DIVU) for the execute stage.
// One quotient bit per cycle; start -> done latency is WIDTH+3 cycles
// (3 cycles when the divisor is zero). busy stalls the pipeline.
// Optional build macro: DIV_FLUSH_EN adds a 'flush' input that abandons an
// operation in flight without touching the result registers.
module div_unit_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
`ifdef DIV_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             start,
  input  logic             isSigned,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divByZero
);

  localparam int CW = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : ((WIDTH > 2) ? $clog2(WIDTH) : 1);
  localparam logic [WIDTH-1:0] DBZ_QUOT = {WIDTH{DIV_DBZ_QUOT[0]}};

  // Sequencer and captured request
  div_state_e       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic             signed_reg;
  logic [WIDTH-1:0] a_reg;        // raw dividend, kept for the divide-by-zero remainder
  logic [WIDTH-1:0] dvs_reg;      // raw divisor until PREP, then its magnitude

  // Iteration datapath: dvd_reg shifts dividend bits out of the top while
  // quotient bits shift in at the bottom, so it ends holding the quotient.
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] rem_reg;
  logic             qneg_reg;
  logic             rneg_reg;
  logic             zero_reg;

  // Registered outputs
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] quot_reg;
  logic [WIDTH-1:0] rem_out_reg;
  logic             dbz_reg;

  logic             flush_w;
  logic [WIDTH-1:0] rem_step;
  logic             qbit_step;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

`ifdef DIV_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Two's complement negation, modulo 2^WIDTH (most-negative maps to itself).
  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  assign mag_a = (signed_reg && a_reg[WIDTH-1])   ? neg(a_reg)   : a_reg;
  assign mag_b = (signed_reg && dvs_reg[WIDTH-1]) ? neg(dvs_reg) : dvs_reg;
  assign q_fix = qneg_reg ? neg(dvd_reg) : dvd_reg;
  assign r_fix = rneg_reg ? neg(rem_reg) : rem_reg;

  div_sub_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (rem_reg),
    .dvd_bit  (dvd_reg[WIDTH-1]),
    .dvs      (dvs_reg),
    .rem_next (rem_step),
    .q_bit    (qbit_step)
  );

  // Divider FSM: sequencing, datapath registers and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      signed_reg  <= 1'b0;
      a_reg       <= '0;
      dvs_reg     <= '0;
      dvd_reg     <= '0;
      rem_reg     <= '0;
      qneg_reg    <= 1'b0;
      rneg_reg    <= 1'b0;
      zero_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      quot_reg    <= '0;
      rem_out_reg <= '0;
      dbz_reg     <= 1'b0;
    end else if (flush_w && (state_reg != IDLE)) begin
      // Abandon the operation; the last delivered result stays visible.
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg      <= dividend;
            dvs_reg    <= divisor;
            signed_reg <= isSigned;
            dbz_reg    <= 1'b0;
            busy_reg   <= 1'b1;
            state_reg  <= PREP;
          end
        end

        PREP: begin
          dvd_reg  <= mag_a;
          dvs_reg  <= mag_b;
          rem_reg  <= '0;
          qneg_reg <= signed_reg & (a_reg[WIDTH-1] ^ dvs_reg[WIDTH-1]);
          rneg_reg <= signed_reg & a_reg[WIDTH-1];
          if (dvs_reg == '0) begin
            zero_reg  <= 1'b1;
            state_reg <= FIX;
          end else begin
            zero_reg  <= 1'b0;
            cnt_reg   <= CW'(WIDTH - 1);
            state_reg <= RUN;
          end
        end

        RUN: begin
          rem_reg <= rem_step;
          dvd_reg <= {dvd_reg[WIDTH-2:0], qbit_step};
          if (cnt_reg == '0) begin
            state_reg <= FIX;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end

        FIX: begin
          if (zero_reg) begin
            quot_reg    <= DBZ_QUOT;
            rem_out_reg <= a_reg;
            dbz_reg     <= 1'b1;
          end else begin
            quot_reg    <= q_fix;
            rem_out_reg <= r_fix;
            dbz_reg     <= 1'b0;
          end
          done_reg  <= 1'b1;
          state_reg <= DONE;
        end

        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign quotient  = quot_reg;
  assign remainder = rem_out_reg;
  assign divByZero = dbz_reg;

endmodule
